avalon_pio_in_irq: RTL and testbench
====================================

Name: avalon_pio_in_irq

Overview:
Parametrised Avalon-MM slave input port with interrupt support, extending the 1-bit read-only PIO input. It synchronises a WIDTH-bit asynchronous input bus and latches selected edges in a sticky edge-capture register. A maskable level interrupt goes to the Nios II IRQ input. Sits in the Platform Designer system alongside the other PIOs (USB GPX/IRQ lines, keys, switches).

Parameters:
WIDTH, 8, number of input bits (1..32)
SYNC_STAGES, 2, flip-flop synchroniser depth on in_port (2..4)
EDGE_TYPE, 0, edge captured: 0 rising, 1 falling, 2 any
BIT_CLEAR, 1, 1: edge-capture write is write-1-to-clear per bit; 0: any write clears all bits

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
address  input  2  Avalon word address
chipselect  input  1  Avalon chip select
write_n  input  1  Avalon write strobe, active low
writedata  input  32  Avalon write data
readdata  output  32  Avalon read data, registered
in_port  input  WIDTH  asynchronous external inputs
irq  output  1  level interrupt, active high

Behaviour:
- Reset: reset_n asynchronous, active-low; clock clk. All of the following are 0 under reset: synchroniser stages, prev register, irqmask, edge_capture, readdata, irq, arm counter.
- Register map (word address): 0 DATA (RO, synchronised input); 1 reserved (reads 0, writes ignored); 2 IRQMASK (RW, WIDTH bits); 3 EDGECAP (RW per BIT_CLEAR).
- Readdata: updated every clk from address, independent of chipselect; fixed read latency 1; WIDTH bits zero-extended to 32.
- Write occurs when chipselect=1 and write_n=0. Writes to addresses 0 and 1 have no effect.
- IRQMASK write: irqmask <= writedata[WIDTH-1:0].
- Synchroniser: in_port passes through SYNC_STAGES flops to produce sync. prev <= sync each cycle.
- Edge vector: rising = sync & ~prev; falling = ~sync & prev; any = sync ^ prev. Selected by EDGE_TYPE. Edge vector is gated to 0 while disarmed.
- Arming: counter increments from 0 after reset until it reaches SYNC_STAGES+1, then holds. Edges are detected only once the counter has saturated. This prevents a level held high through reset from producing a spurious edge.
- Edge capture, per bit each cycle:
  - BIT_CLEAR=1, EDGECAP write: cap <= (cap & ~writedata) | edge.
  - BIT_CLEAR=0, EDGECAP write: cap <= edge.
  - Otherwise: cap <= cap | edge.
  - A new edge in the same cycle as its clear wins; the bit stays set.
- irq = |(edge_capture & irqmask). Registered, so it asserts the cycle after the capture bit sets. Changing the mask affects irq one cycle after the write.
- Latency from in_port transition (stable input, post-arm): synchronised value appears at edge SYNC_STAGES. The capture bit sets at edge SYNC_STAGES+1. irq asserts at edge SYNC_STAGES+2.
- Pulses shorter than one clk may be missed; this is by design, not an error.
- Reset asserted mid-operation clears all state immediately and re-enters the disarmed phase.

Decomposition:
- Shared package pio_pkg: address constants ADDR_DATA=0, ADDR_IRQMASK=2, ADDR_EDGECAP=3; EDGE_RISING/EDGE_FALLING/EDGE_ANY encodings.
- One sub-module, pio_sync_edge (WIDTH, SYNC_STAGES, EDGE_TYPE): synchroniser, prev register, arm counter, edge vector output.
- The top level holds the register file, Avalon decode and irq.

Test Plan:
- Reset with in_port=8'hFF held through reset, release -> readdata at addr 0 reads 0x000000FF after sync latency; EDGECAP stays 0 and irq=0 for 20 cycles.
- WIDTH=8, EDGE_TYPE=0, IRQMASK=0x01, in_port 0x00->0x01 -> EDGECAP=0x01 at edge SYNC_STAGES+1, irq=1 one cycle later; addr 0 read returns 0x00000001 with latency 1.
- Write EDGECAP=0x01 (BIT_CLEAR=1) -> bit cleared, irq deasserts next cycle. Repeat with a new rising edge on bit 0 landing in the clear cycle -> EDGECAP stays 0x01, irq stays 1.
- IRQMASK=0x00 with EDGECAP=0x0F -> irq=0. Write IRQMASK=0x04 -> irq=1 one cycle later; reads of addr 2 return 0x00000004.
- EDGE_TYPE=2, BIT_CLEAR=0: toggle bit 3 high then low -> EDGECAP=0x08 after each toggle; any write to addr 3 clears EDGECAP to 0x00.
- Assert reset_n low mid-capture (EDGECAP=0xA5, irq=1) -> readdata, irq, irqmask and EDGECAP are 0 immediately (asynchronously); writes to addresses 0 and 1 leave all state unchanged.

Source files
------------

// File: rtl/pio_pkg.sv
// Shared constants for the Avalon PIO input block:
// register word addresses and edge-select encodings.
package pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/avalon_pio_in_irq_if.sv
// Avalon-MM slave bus bundle for the PIO input block.
// Master drives address/strobes, slave returns readdata.
interface avalon_pio_in_irq_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

endinterface

// File: rtl/pio_sync_edge.sv
// Input synchroniser, previous-value register, arm counter
// and edge vector for the PIO input block.
module pio_sync_edge
  import pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] edges
);

  localparam logic [2:0] ARM_MAX = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] stage [SYNC_STAGES];
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] raw;
  logic [2:0]       arm_cnt;
  logic             armed;

  assign sync  = stage[SYNC_STAGES-1];
  assign armed = (arm_cnt == ARM_MAX);

  // Multi-flop synchroniser chain on the asynchronous inputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  // Previous synchronised value for edge comparison
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev <= '0;
    end else begin
      prev <= sync;
    end
  end

  // Arm counter: hold off edges until the chain has flushed
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_cnt <= '0;
    end else if (!armed) begin
      arm_cnt <= arm_cnt + 3'd1;
    end
  end

  // Select the edge flavour and gate it while disarmed
  always_comb begin
    raw = '0;
    case (EDGE_TYPE)
      EDGE_FALLING: raw = ~sync & prev;
      EDGE_ANY:     raw = sync ^ prev;
      default:      raw = sync & ~prev;
    endcase
    edges = armed ? raw : '0;
  end

endmodule

// File: rtl/avalon_pio_in_irq.sv
// Avalon-MM PIO input with sticky edge capture and a
// maskable level interrupt towards the Nios II.
module avalon_pio_in_irq
  import pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISING,
  parameter int BIT_CLEAR   = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  avalon_pio_in_irq_if.slave    bus,
  input  logic [WIDTH-1:0]      in_port,
  output logic                  irq
);

  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] edges;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] cap_next;
  logic [WIDTH-1:0] wd;
  logic [31:0]      rd_next;
  logic             wr_en;
  logic             mask_we;
  logic             cap_we;
  logic             unused_wd;

  assign wd        = bus.writedata[WIDTH-1:0];
  assign unused_wd = ^bus.writedata;
  assign wr_en     = bus.chipselect & ~bus.write_n;
  assign mask_we   = wr_en && (bus.address == ADDR_IRQMASK);
  assign cap_we    = wr_en && (bus.address == ADDR_EDGECAP);

  pio_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_sync_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .in_port (in_port),
    .sync    (sync),
    .edges   (edges)
  );

  // Edge capture update; a fresh edge always beats a clear
  always_comb begin
    cap_next = edge_capture | edges;
    if (cap_we) begin
      if (BIT_CLEAR != 0) begin
        cap_next = (edge_capture & ~wd) | edges;
      end else begin
        cap_next = edges;
      end
    end
  end

  // Read mux, zero-extended to the 32-bit bus
  always_comb begin
    rd_next = '0;
    case (bus.address)
      ADDR_DATA:    rd_next = 32'(sync);
      ADDR_RSVD:    rd_next = '0;
      ADDR_IRQMASK: rd_next = 32'(irqmask);
      ADDR_EDGECAP: rd_next = 32'(edge_capture);
      default:      rd_next = '0;
    endcase
  end

  // Interrupt mask register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask <= '0;
    end else if (mask_we) begin
      irqmask <= wd;
    end
  end

  // Sticky edge capture register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_capture <= '0;
    end else begin
      edge_capture <= cap_next;
    end
  end

  // Registered level interrupt
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else begin
      irq <= |(edge_capture & irqmask);
    end
  end

  // Registered readdata, one cycle latency
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.readdata <= '0;
    end else begin
      bus.readdata <= rd_next;
    end
  end

endmodule

// File: tb/tb_avalon_pio_in_irq.sv
// Bench for avalon_pio_in_irq: two instances (rising/W1C and
// any-edge/clear-all) checked against a history-based model.
module tb_avalon_pio_in_irq;

  localparam int S = 2;
  localparam int HN = 1024;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  in_a, in_b;
  logic        irq_a, irq_b;
  logic [1:0]  addr [2];
  logic        cs   [2];
  logic        wn   [2];
  logic [31:0] wd   [2];

  avalon_pio_in_irq_if bus_a ();
  avalon_pio_in_irq_if bus_b ();

  assign bus_a.address    = addr[0];
  assign bus_a.chipselect = cs[0];
  assign bus_a.write_n    = wn[0];
  assign bus_a.writedata  = wd[0];
  assign bus_b.address    = addr[1];
  assign bus_b.chipselect = cs[1];
  assign bus_b.write_n    = wn[1];
  assign bus_b.writedata  = wd[1];

  avalon_pio_in_irq #(
    .WIDTH(8), .SYNC_STAGES(S), .EDGE_TYPE(0), .BIT_CLEAR(1)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a),
    .in_port(in_a), .irq(irq_a)
  );

  avalon_pio_in_irq #(
    .WIDTH(8), .SYNC_STAGES(S), .EDGE_TYPE(2), .BIT_CLEAR(0)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b),
    .in_port(in_b), .irq(irq_b)
  );

  // Model: input history per instance, indexed by edge count since reset
  logic [7:0]  hist [2][HN];
  int          t;
  logic [7:0]  m_cap  [2];
  logic [7:0]  m_mask [2];
  logic [31:0] m_rd   [2];
  logic        m_irq  [2];

  function automatic logic [7:0] hsamp(int i, int k);
    if (k < 1) return 8'h00;
    return hist[i][k % HN];
  endfunction

  // Synchronised view before edge tc is the input seen S edges earlier;
  // edges only count once both compared samples are post-reset.
  function automatic logic [7:0] edge_of(int i, int tc);
    logic [7:0] cur, old;
    if (tc - S - 1 < 1) return 8'h00;
    cur = hsamp(i, tc - S);
    old = hsamp(i, tc - S - 1);
    return (i == 0) ? (cur & ~old) : (cur ^ old);
  endfunction

  function automatic logic [31:0] exp_read(int i, logic [1:0] a, int tc);
    case (a)
      2'd0:    return {24'h0, hsamp(i, tc - S)};
      2'd2:    return {24'h0, m_mask[i]};
      2'd3:    return {24'h0, m_cap[i]};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [7:0] next_cap(int i, int tc);
    logic [7:0] e;
    e = edge_of(i, tc);
    if (cs[i] && !wn[i] && addr[i] == 2'd3) begin
      if (i == 0) return (m_cap[i] & ~wd[i][7:0]) | e;
      return e;
    end
    return m_cap[i] | e;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t <= 0;
      for (int i = 0; i < 2; i++) begin
        m_cap[i]  <= 8'h00;
        m_mask[i] <= 8'h00;
        m_rd[i]   <= 32'h0;
        m_irq[i]  <= 1'b0;
      end
    end else begin
      t <= t + 1;
      hist[0][(t + 1) % HN] <= in_a;
      hist[1][(t + 1) % HN] <= in_b;
      for (int i = 0; i < 2; i++) begin
        m_rd[i]  <= exp_read(i, addr[i], t + 1);
        m_irq[i] <= |(m_cap[i] & m_mask[i]);
        m_cap[i] <= next_cap(i, t + 1);
        if (cs[i] && !wn[i] && addr[i] == 2'd2)
          m_mask[i] <= wd[i][7:0];
      end
    end
  end

  int checks = 0;
  int passes = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    chk("model_rd_a", bus_a.readdata, m_rd[0]);
    chk("model_irq_a", {31'h0, irq_a}, {31'h0, m_irq[0]});
    chk("model_rd_b", bus_b.readdata, m_rd[1]);
    chk("model_irq_b", {31'h0, irq_b}, {31'h0, m_irq[1]});
  endtask

  task automatic wr(int i, logic [1:0] a, logic [31:0] d);
    addr[i] = a;
    cs[i]   = 1'b1;
    wn[i]   = 1'b0;
    wd[i]   = d;
    tick();
    cs[i]   = 1'b0;
    wn[i]   = 1'b1;
  endtask

  initial begin
    in_a = 8'hFF;
    in_b = 8'h00;
    for (int i = 0; i < 2; i++) begin
      addr[i] = 2'd0; cs[i] = 1'b0; wn[i] = 1'b1; wd[i] = 32'h0;
    end
    repeat (3) tick();
    reset_n = 1'b1;

    // Level held high through reset: data visible, no edge
    wr(0, 2'd2, 32'hFF);
    addr[0] = 2'd0;
    repeat (4) tick();
    chk("data_after_reset", bus_a.readdata, 32'h0000_00FF);
    addr[0] = 2'd3;
    repeat (20) tick();
    chk("no_spurious_cap", bus_a.readdata, 32'h0);
    chk("no_spurious_irq", {31'h0, irq_a}, 32'h0);

    // Rising edge on bit 0: capture at edge S+1, irq at S+2
    wr(0, 2'd2, 32'h01);
    in_a = 8'h00;
    repeat (5) tick();
    addr[0] = 2'd3;
    in_a = 8'h01;
    repeat (3) tick();
    chk("cap_before_set", bus_a.readdata, 32'h0);
    chk("irq_before_set", {31'h0, irq_a}, 32'h0);
    tick();
    chk("cap_set", bus_a.readdata, 32'h01);
    chk("irq_set", {31'h0, irq_a}, 32'h1);
    addr[0] = 2'd0;
    tick();
    chk("data_bit0", bus_a.readdata, 32'h01);

    // W1C clear, then a clear colliding with a fresh edge
    wr(0, 2'd3, 32'h01);
    chk("irq_hold_on_clear", {31'h0, irq_a}, 32'h1);
    tick();
    chk("irq_drop_after_clear", {31'h0, irq_a}, 32'h0);
    chk("cap_cleared", bus_a.readdata, 32'h0);
    in_a = 8'h00; repeat (5) tick();
    in_a = 8'h01; repeat (5) tick();
    chk("irq_reset_edge", {31'h0, irq_a}, 32'h1);
    in_a = 8'h00; repeat (5) tick();
    in_a = 8'h01; tick(); tick();
    wr(0, 2'd3, 32'h01);
    repeat (3) tick();
    chk("cap_edge_wins", bus_a.readdata, 32'h01);
    chk("irq_edge_wins", {31'h0, irq_a}, 32'h1);

    // Mask gating
    wr(0, 2'd2, 32'h00);
    in_a = 8'h00; repeat (5) tick();
    in_a = 8'h0F; repeat (5) tick();
    addr[0] = 2'd3;
    tick();
    chk("cap_0f", bus_a.readdata, 32'h0F);
    chk("irq_masked", {31'h0, irq_a}, 32'h0);
    wr(0, 2'd2, 32'h04);
    chk("irq_mask_lag", {31'h0, irq_a}, 32'h0);
    tick();
    chk("irq_unmasked", {31'h0, irq_a}, 32'h1);
    addr[0] = 2'd2;
    tick();
    chk("mask_read", bus_a.readdata, 32'h04);

    // Any-edge, clear-all instance
    wr(1, 2'd2, 32'h08);
    in_b = 8'h08; repeat (5) tick();
    addr[1] = 2'd3;
    tick();
    chk("b_cap_rise", bus_b.readdata, 32'h08);
    chk("b_irq_rise", {31'h0, irq_b}, 32'h1);
    wr(1, 2'd3, 32'h0);
    tick();
    chk("b_cap_clr1", bus_b.readdata, 32'h0);
    in_b = 8'h00; repeat (5) tick();
    chk("b_cap_fall", bus_b.readdata, 32'h08);
    wr(1, 2'd3, 32'h1234);
    tick();
    chk("b_cap_clr2", bus_b.readdata, 32'h0);

    // Build A5 capture, check ignored writes, then async reset
    wr(0, 2'd3, 32'hFF);
    wr(0, 2'd2, 32'hFF);
    in_a = 8'h00; repeat (5) tick();
    in_a = 8'hA5; repeat (5) tick();
    addr[0] = 2'd3;
    tick();
    chk("cap_a5", bus_a.readdata, 32'hA5);
    chk("irq_a5", {31'h0, irq_a}, 32'h1);
    wr(0, 2'd0, 32'h0);
    wr(0, 2'd1, 32'hFFFF_FFFF);
    addr[0] = 2'd2;
    tick();
    chk("mask_kept", bus_a.readdata, 32'hFF);
    addr[0] = 2'd3;
    tick();
    chk("cap_kept", bus_a.readdata, 32'hA5);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rd_a", bus_a.readdata, 32'h0);
    chk("async_irq_a", {31'h0, irq_a}, 32'h0);
    chk("async_rd_b", bus_b.readdata, 32'h0);
    chk("async_irq_b", {31'h0, irq_b}, 32'h0);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (6) tick();
    addr[0] = 2'd2;
    tick();
    chk("mask_after_reset", bus_a.readdata, 32'h0);
    addr[0] = 2'd3;
    tick();
    chk("cap_after_reset", bus_a.readdata, 32'h0);
    chk("irq_after_reset", {31'h0, irq_a}, 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
